// File: rtl/conv1d_mc_engine_if.sv
// Stream interface for conv1d_mc_engine.
// Carries the sample input stream and the packed multi-channel output stream.
//   in_valid / in_ready / in_data     : signed input samples, producer -> engine
//   out_valid / out_ready / out_data  : packed output vectors, engine -> consumer
// master modport: the data mover / consumer side. slave modport: the engine.
interface conv1d_mc_engine_if #(
    parameter int DATA_W = 16,
    parameter int NUM_CH = 4
);
    logic                     in_valid;
    logic                     in_ready;
    logic [DATA_W-1:0]        in_data;
    logic                     out_valid;
    logic                     out_ready;
    logic [NUM_CH*DATA_W-1:0] out_data;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/conv1d_mc_engine.sv
// Multi-channel 1D valid-mode convolution engine.
// One signed input stream feeds NUM_CH parallel MACs, each with its own
// runtime-length kernel (1..MAX_K taps). Results are arithmetic-shifted,
// saturated to DATA_W and presented as one packed output vector.
// Ports:
//   clk_i, rst_ni           clock, async active-low reset
//   coef_we_i/ch/idx/data   coefficient RAM write (IDLE only)
//   start_i, abort_i        operation control
//   len_i, ksize_i, shift_i run configuration, latched at start
//   bus (slave)             input / output streams with valid-ready
//   busy_o                  high while running
//   cfg_err_o               one-cycle pulse on a rejected start
//   done_int_o              one-cycle completion pulse
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for start; coefficient writes accepted
// RUN   | streaming samples in, output vectors out
// DONE  | final vector handed off; raises done_int_o for one cycle
module conv1d_mc_engine #(
    parameter  int DATA_W = 16,
    parameter  int ACC_W  = 40,
    parameter  int MAX_K  = 8,
    parameter  int NUM_CH = 4,
    parameter  int LEN_W  = 16,
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int IDX_W  = (MAX_K > 1) ? $clog2(MAX_K) : 1,
    localparam int KS_W   = IDX_W + 1,
    localparam int SH_W   = $clog2(ACC_W)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              coef_we_i,
    input  logic [CH_W-1:0]   coef_ch_i,
    input  logic [IDX_W-1:0]  coef_idx_i,
    input  logic [DATA_W-1:0] coef_data_i,
    input  logic              start_i,
    input  logic              abort_i,
    input  logic [LEN_W-1:0]  len_i,
    input  logic [KS_W-1:0]   ksize_i,
    input  logic [SH_W-1:0]   shift_i,
    conv1d_mc_engine_if.slave bus,
    output logic              busy_o,
    output logic              cfg_err_o,
    output logic              done_int_o
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam int PW = 2 * DATA_W;
    localparam logic [KS_W-1:0] MAX_K_V = KS_W'(MAX_K);
    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    logic [1:0]               state_q, state_d;
    logic signed [DATA_W-1:0] coef_q [NUM_CH][MAX_K];
    logic signed [DATA_W-1:0] win_q  [MAX_K];
    logic signed [DATA_W-1:0] win_d  [MAX_K];
    logic [LEN_W-1:0]         n_q, cnt_q, out_rem_q;
    logic [KS_W-1:0]          k_q;
    logic [SH_W-1:0]          shift_q;
    logic                     out_valid_q, cfg_err_q;
    logic [NUM_CH*DATA_W-1:0] out_data_q, mac_vec;

    logic idle, run, cfg_ok, start_ok, abort_hit;
    logic in_ready, in_fire, out_fire, win_full;
    logic [LEN_W:0] taken_nx;
    int k_int;
    logic signed [PW-1:0]    prod;
    logic signed [ACC_W-1:0] acc, sh;

    assign idle      = (state_q == S_IDLE);
    assign run       = (state_q == S_RUN);
    assign cfg_ok    = (ksize_i != '0) && (ksize_i <= MAX_K_V) && (len_i >= LEN_W'(ksize_i));
    assign start_ok  = idle && start_i && cfg_ok;
    assign abort_hit = abort_i && !idle;

    // A new sample may enter in the same cycle the pending vector drains.
    assign in_ready = run && (cnt_q < n_q) && (!out_valid_q || bus.out_ready);
    assign in_fire  = in_ready && bus.in_valid;
    assign out_fire = out_valid_q && bus.out_ready;
    assign taken_nx = {1'b0, cnt_q} + (LEN_W+1)'(1);
    assign win_full = taken_nx >= (LEN_W+1)'(k_q);
    assign k_int    = int'(k_q);

    // Window shifts toward tap 0; the newest sample lands at tap K-1 and
    // taps beyond the active kernel are held at zero.
    always_comb begin
        for (int i = 0; i < MAX_K; i++) win_d[i] = win_q[i];
        if (in_fire) begin
            for (int i = 0; i < MAX_K; i++) begin
                if (i == k_int - 1)  win_d[i] = bus.in_data;
                else if (i >= k_int) win_d[i] = '0;
            end
            for (int i = 0; i < MAX_K - 1; i++) begin
                if (i < k_int - 1) win_d[i] = win_q[i+1];
            end
        end
    end

    always_comb begin
        mac_vec = '0;
        prod    = '0;
        acc     = '0;
        sh      = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            acc = '0;
            for (int j = 0; j < MAX_K; j++) begin
                if (j < k_int) begin
                    prod = PW'(coef_q[c][j]) * PW'(win_d[j]);
                    acc  = acc + ACC_W'(prod);
                end
            end
            sh = acc >>> shift_q;
            if (sh > SAT_MAX)      mac_vec[c*DATA_W +: DATA_W] = SAT_MAX[DATA_W-1:0];
            else if (sh < SAT_MIN) mac_vec[c*DATA_W +: DATA_W] = SAT_MIN[DATA_W-1:0];
            else                   mac_vec[c*DATA_W +: DATA_W] = sh[DATA_W-1:0];
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start_ok) state_d = S_RUN;
            S_RUN:   if (out_fire && out_rem_q == LEN_W'(1)) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (abort_hit) state_d = S_IDLE;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= S_IDLE;
            n_q         <= '0;
            k_q         <= '0;
            shift_q     <= '0;
            cnt_q       <= '0;
            out_rem_q   <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            cfg_err_q   <= 1'b0;
            for (int i = 0; i < MAX_K; i++) win_q[i] <= '0;
            for (int c = 0; c < NUM_CH; c++)
                for (int j = 0; j < MAX_K; j++) coef_q[c][j] <= '0;
        end else begin
            state_q   <= state_d;
            cfg_err_q <= idle && start_i && !cfg_ok;
            if (idle && coef_we_i) coef_q[coef_ch_i][coef_idx_i] <= coef_data_i;
            if (start_ok) begin
                n_q         <= len_i;
                k_q         <= ksize_i;
                shift_q     <= shift_i;
                cnt_q       <= '0;
                out_rem_q   <= len_i - LEN_W'(ksize_i) + LEN_W'(1);
                out_valid_q <= 1'b0;
                for (int i = 0; i < MAX_K; i++) win_q[i] <= '0;
            end else if (abort_hit) begin
                out_valid_q <= 1'b0;
            end else begin
                if (in_fire) begin
                    cnt_q <= cnt_q + LEN_W'(1);
                    for (int i = 0; i < MAX_K; i++) win_q[i] <= win_d[i];
                end
                if (out_fire) out_rem_q <= out_rem_q - LEN_W'(1);
                if (in_fire && win_full) begin
                    out_valid_q <= 1'b1;
                    out_data_q  <= mac_vec;
                end else if (out_fire) begin
                    out_valid_q <= 1'b0;
                end
            end
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign busy_o        = run;
    assign cfg_err_o     = cfg_err_q;
    // Abort in DONE suppresses the completion pulse in that same cycle.
    assign done_int_o    = (state_q == S_DONE) && !abort_i;
endmodule
